// File: rtl/vga_token_writer.sv
// vga_token_writer: converts digit/answer tokens to ASCII writes at a wrapping cursor and owns the screen clear.
// Optional leading-zero suppression for 32-bit answers: define VGA_TOKEN_WRITER_ZERO_SUPPRESS_EN.
module vga_token_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tok_strobe,
  input  logic [5:0]        tok_size,
  input  logic [31:0]       tok_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [ADDR_W-1:0] cursor
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);
  typedef enum logic [1:0] {IDLE, EMIT, CLEAR} state_t;
  state_t state, state_n;
  logic [2:0] rem, rem_n;
  logic [31:0] sh, sh_n, lead;
  logic [3:0] sig;
  logic [ADDR_W-1:0] cur_n, wa_n, cur_inc;
  logic [7:0] wc_n;
  logic we_n, busy_n, ovf_n;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] sym(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} :
           n == 4'hA ? 8'h2B : n == 4'hB ? 8'h2D : n == 4'hC ? 8'h2A :
           n == 4'hD ? 8'h2F : n == 4'hE ? 8'h3D : 8'h20;
  endfunction

  // sig = number of nibbles to print; lead = answer with first printed nibble at the top
  always_comb begin
`ifdef VGA_TOKEN_WRITER_ZERO_SUPPRESS_EN
    sig = 4'd1;
    for (int i = 1; i < 8; i++) if (tok_data[4*i +: 4] != 4'h0) sig = 4'(i + 1);
`else
    sig = 4'd8;
`endif
    lead = tok_data << {4'd8 - sig, 2'b00};
  end

  assign cur_inc = cursor == LAST ? '0 : cursor + ADDR_W'(1);

  always_comb begin
    state_n = state;
    rem_n = rem;
    sh_n = sh;
    cur_n = cursor;
    we_n = 1'b0;
    wa_n = wr_addr;
    wc_n = wr_char;
    busy_n = 1'b0;
    ovf_n = ovf | (busy & (tok_strobe | clr_req));
    case (state)
      IDLE: begin
        if (!busy && clr_req) begin
          state_n = CLEAR;
          we_n = 1'b1;
          wa_n = '0;
          wc_n = 8'h20;
          cur_n = ADDR_W'(1);
          busy_n = 1'b1;
        end else if (!busy && tok_strobe) begin
          we_n = 1'b1;
          wa_n = cursor;
          cur_n = cur_inc;
          busy_n = 1'b1;
          if (tok_size == 6'd32) begin
            wc_n = hex(lead[31:28]);
            sh_n = lead << 4;
            rem_n = 3'(sig - 4'd1);
            state_n = sig > 4'd1 ? EMIT : IDLE;
          end else wc_n = sym(tok_data[3:0]);
        end
      end
      EMIT: begin
        we_n = 1'b1;
        wa_n = cursor;
        wc_n = hex(sh[31:28]);
        sh_n = sh << 4;
        cur_n = cur_inc;
        rem_n = rem - 3'd1;
        busy_n = 1'b1;
        state_n = rem == 3'd1 ? IDLE : EMIT;
      end
      CLEAR: begin
        we_n = 1'b1;
        wa_n = cursor;
        wc_n = 8'h20;
        cur_n = cur_inc;
        busy_n = 1'b1;
        if (cursor == LAST) begin
          state_n = IDLE;
          ovf_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      sh <= '0;
      cursor <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_char <= '0;
      busy <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      sh <= sh_n;
      cursor <= cur_n;
      wr_en <= we_n;
      wr_addr <= wa_n;
      wr_char <= wc_n;
      busy <= busy_n;
      ovf <= ovf_n;
    end
  end
endmodule

// File: tb/tb_vga_token_writer.sv
// tb_vga_token_writer: scoreboard bench for vga_token_writer (40x30 screen).
module tb_vga_token_writer;
  localparam int N = 1200;
  logic clock = 0, reset = 1, tok_strobe = 0, clr_req = 0;
  logic [5:0] tok_size = 0;
  logic [31:0] tok_data = 0;
  logic busy, ovf, wr_en;
  logic [10:0] wr_addr, cursor;
  logic [7:0] wr_char;
  int passed = 0, total = 0, cur = 0;
  logic [18:0] exp_q[$];
  string hexs = "0123456789ABCDEF";
  string syms = "0123456789+-*/= ";

  vga_token_writer dut (
    .clock(clock), .reset(reset), .tok_strobe(tok_strobe), .tok_size(tok_size),
    .tok_data(tok_data), .clr_req(clr_req), .busy(busy), .ovf(ovf), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .cursor(cursor)
  );

  always #5 clock = ~clock;

  task automatic expect_tok(input logic [5:0] s, input logic [31:0] d);
    if (s != 6'd32) begin
      exp_q.push_back({11'(cur), syms[d[3:0]]});
      cur = (cur + 1) % N;
    end else begin
      int first = 0;
`ifdef VGA_TOKEN_WRITER_ZERO_SUPPRESS_EN
      while (first < 7 && d[31-4*first -: 4] == 4'h0) first++;
`endif
      for (int i = first; i < 8; i++) begin
        exp_q.push_back({11'(cur), hexs[d[31-4*i -: 4]]});
        cur = (cur + 1) % N;
      end
    end
  endtask

  task automatic send(input logic [5:0] s, input logic [31:0] d, input logic c);
    @(negedge clock);
    tok_size = s; tok_data = d; tok_strobe = 1; clr_req = c;
    @(negedge clock);
    tok_strobe = 0; clr_req = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0; cur = 0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
    total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else passed++;
    total++; if (wr_addr !== 11'd0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else passed++;
    total++; if (wr_char !== 8'd0) $display("FAIL reset_wr_char got %h want 00", wr_char); else passed++;
    total++; if (cursor !== 11'd0) $display("FAIL reset_cursor got %0d want 0", cursor); else passed++;
  endtask

  task automatic test_single();
    logic [18:0] e;
    logic [5:0] sz[10] = '{4, 4, 4, 4, 4, 4, 4, 4, 7, 0};
    logic [31:0] dv[10] = '{0, 9, 'hA, 'hB, 'hC, 'hD, 'hE, 'hF, 'hFFFFFFF3, 'h12};
    expect_tok(4, 32'h7);
    send(4, 32'h7, 0);
    e = exp_q.pop_front();
    total++;
    if (wr_en !== 1'b1 || {wr_addr, wr_char} !== e)
      $display("FAIL single_write got en=%b %0d/%h want 1 %0d/%h", wr_en, wr_addr, wr_char, e[18:8], e[7:0]);
    else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_hi got %b want 1", busy); else passed++;
    total++; if (cursor !== 11'd1) $display("FAIL single_cursor got %0d want 1", cursor); else passed++;
    @(negedge clock);
    total++; if (busy !== 1'b0 || wr_en !== 1'b0) $display("FAIL single_busy_lo got busy=%b en=%b want 0 0", busy, wr_en); else passed++;
    fork
      foreach (dv[i]) begin
        expect_tok(sz[i], dv[i]);
        send(sz[i], dv[i], 0);
      end
      for (int c = 0; c < 24; c++) begin
        @(negedge clock);
        if (wr_en) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL map_extra got %0d/%h want none", wr_addr, wr_char);
          else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_char} !== e) $display("FAIL map_write got %0d/%h want %0d/%h", wr_addr, wr_char, e[18:8], e[7:0]);
            else passed++;
          end
        end
      end
    join
    total++; if (exp_q.size() != 0) $display("FAIL map_missing got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_word();
    logic [18:0] e;
    logic [31:0] dv[3] = '{32'h000001F3, 32'h0, 32'hDEADBEEF};
    fork
      foreach (dv[i]) begin
        expect_tok(32, dv[i]);
        send(32, dv[i], 0);
        repeat (8) @(negedge clock);
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        if (wr_en) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL word_extra got %0d/%h want none", wr_addr, wr_char);
          else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_char} !== e) $display("FAIL word_write got %0d/%h want %0d/%h", wr_addr, wr_char, e[18:8], e[7:0]);
            else passed++;
          end
        end
      end
    join
    total++; if (exp_q.size() != 0) $display("FAIL word_missing got %0d left want 0", exp_q.size()); else passed++;
    total++; if (cursor !== 11'(cur)) $display("FAIL word_cursor got %0d want %0d", cursor, cur); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL word_ovf got %b want 0", ovf); else passed++;
  endtask

  task automatic test_overflow();
    logic [18:0] e;
    fork
      begin
        expect_tok(32, 32'h12345678);
        send(32, 32'h12345678, 0);
        @(negedge clock);
        tok_size = 4; tok_data = 32'hC; tok_strobe = 1;
        @(negedge clock);
        tok_strobe = 0;
      end
      for (int c = 0; c < 14; c++) begin
        @(negedge clock);
        if (wr_en) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL ovf_extra got %0d/%h want none", wr_addr, wr_char);
          else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_char} !== e) $display("FAIL ovf_write got %0d/%h want %0d/%h", wr_addr, wr_char, e[18:8], e[7:0]);
            else passed++;
          end
        end
      end
    join
    total++; if (exp_q.size() != 0) $display("FAIL ovf_missing got %0d left want 0", exp_q.size()); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else passed++;
    total++; if (cursor !== 11'(cur)) $display("FAIL ovf_cursor got %0d want %0d", cursor, cur); else passed++;
  endtask

  task automatic test_wrap();
    logic [18:0] e;
    int cnt = (N - 2 - cur + N) % N;
    fork
      begin
        for (int i = 0; i < cnt; i++) begin
          expect_tok(4, 32'h5);
          send(4, 32'h5, 0);
        end
        expect_tok(32, 32'h89ABCDEF);
        send(32, 32'h89ABCDEF, 0);
      end
      for (int c = 0; c < 2 * cnt + 20; c++) begin
        @(negedge clock);
        if (wr_en) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL wrap_extra got %0d/%h want none", wr_addr, wr_char);
          else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_char} !== e) $display("FAIL wrap_write got %0d/%h want %0d/%h", wr_addr, wr_char, e[18:8], e[7:0]);
            else passed++;
          end
        end
      end
    join
    total++; if (exp_q.size() != 0) $display("FAIL wrap_missing got %0d left want 0", exp_q.size()); else passed++;
    total++; if (cursor !== 11'd6) $display("FAIL wrap_cursor got %0d want 6", cursor); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] e;
    logic [31:0] d = 32'h89ABCDEF;
    for (int k = 0; k < 3; k++) exp_q.push_back({11'((cur + k) % N), hexs[d[31-4*k -: 4]]});
    send(32, d, 0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (wr_en !== 1'b1 || {wr_addr, wr_char} !== e)
        $display("FAIL rstmid_write got en=%b %0d/%h want 1 %0d/%h", wr_en, wr_addr, wr_char, e[18:8], e[7:0]);
      else passed++;
    end
    reset = 1;
    @(negedge clock);
    reset = 0; cur = 0;
    total++; if (wr_en !== 1'b0) $display("FAIL rstmid_wr_en got %b want 0", wr_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", ovf); else passed++;
    total++; if (cursor !== 11'd0) $display("FAIL rstmid_cursor got %0d want 0", cursor); else passed++;
    @(negedge clock);
    total++; if (wr_en !== 1'b0) $display("FAIL rstmid_quiet got %b want 0", wr_en); else passed++;
    expect_tok(4, 32'h5);
    send(4, 32'h5, 0);
    e = exp_q.pop_front();
    total++;
    if (wr_en !== 1'b1 || {wr_addr, wr_char} !== e)
      $display("FAIL rstmid_after got en=%b %0d/%h want 1 %0d/%h", wr_en, wr_addr, wr_char, e[18:8], e[7:0]);
    else passed++;
  endtask

  task automatic test_clear();
    logic [18:0] e;
    for (int i = 0; i < N; i++) exp_q.push_back({11'(i), 8'h20});
    fork
      begin
        send(4, 32'h3, 1);
        repeat (5) @(negedge clock);
        total++; if (ovf !== 1'b0) $display("FAIL clear_ovf_same got %b want 0", ovf); else passed++;
        tok_size = 4; tok_data = 32'h1; tok_strobe = 1;
        @(negedge clock);
        tok_strobe = 0;
        @(negedge clock);
        total++; if (ovf !== 1'b1) $display("FAIL clear_ovf_drop got %b want 1", ovf); else passed++;
      end
      for (int c = 0; c < N + 15; c++) begin
        @(negedge clock);
        if (wr_en) begin
          total++;
          if (exp_q.size() == 0) $display("FAIL clear_extra got %0d/%h want none", wr_addr, wr_char);
          else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_char} !== e) $display("FAIL clear_write got %0d/%h want %0d/%h", wr_addr, wr_char, e[18:8], e[7:0]);
            else passed++;
          end
        end
      end
    join
    cur = 0;
    total++; if (exp_q.size() != 0) $display("FAIL clear_missing got %0d left want 0", exp_q.size()); else passed++;
    total++; if (cursor !== 11'd0) $display("FAIL clear_cursor got %0d want 0", cursor); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL clear_ovf_end got %b want 0", ovf); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL clear_busy got %b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_word();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_token_writer.md
# vga_token_writer

Sequencer between the calculator control FSM and the VGA character memory. It accepts one token per strobe (a 4-bit digit/sign or a 32-bit answer), converts it to ASCII characters, and writes them one per clock at a wrapping cursor. It also owns the screen-clear sweep, so the control FSM never addresses screen memory directly. It replaces direct strobing of the VGA buffer and guarantees that writes are never interleaved.

## Interface
Parameters:
- COLS, 40, characters per row
- ROWS, 30, rows on screen
- ADDR_W, 11, width of character address; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- tok_strobe  in  1  one-cycle request to write a token
- tok_size  in  6  token width in bits; 4 = single token, 32 = answer word
- tok_data  in  32  token value; for size 4 only bits [3:0] used
- clr_req  in  1  one-cycle request to blank the screen and home the cursor
- busy  out  1  high while a token or clear is in progress
- ovf  out  1  sticky: a strobe or clear arrived while busy
- wr_en  out  1  character memory write enable
- wr_addr  out  ADDR_W  character memory address
- wr_char  out  8  ASCII character to write
- cursor  out  ADDR_W  next free cell

## Operation
- States: IDLE, EMIT, CLEAR.
- IDLE + clr_req -> CLEAR. Priority applies: if clr_req and tok_strobe occur in the same cycle, the clear wins and the token is discarded. ovf is not set for this case.
- IDLE + tok_strobe -> EMIT. tok_size and tok_data are latched. tok_size values other than 4 or 32 are handled as 4.
- Size-4 character map:
  - 0–9 -> '0'–'9' (0x30–0x39)
  - A -> '+'
  - B -> '-'
  - C -> '*'
  - D -> '/'
  - E -> '='
  - F -> ' '
- Size 32: nibbles are emitted MSB first as hex, '0'–'9' then 'A'–'F' (0x41–0x46). The number of characters is 8, subject to Configuration.
- EMIT: each cycle asserts wr_en with wr_addr = cursor, then increments cursor. After cell COLS*ROWS-1 the cursor wraps to 0. The state returns to IDLE after the last character.
- CLEAR: writes ' ' to addresses 0 through COLS*ROWS-1, one per cycle, then sets cursor = 0 and clears ovf. The state then returns to IDLE.
- A tok_strobe or clr_req while busy=1 is dropped and sets ovf=1. Only reset or a completed clear clears ovf.
- Reset values: state IDLE, busy 0, ovf 0, wr_en 0, wr_addr 0, wr_char 0, cursor 0.
- Reset mid-EMIT or mid-CLEAR: no wr_en in the following cycle, and all outputs take their reset values.

## Timing
- Request sampled at edge n. The first wr_en is registered at edge n+1, so it is visible in cycle n+1.
- Outputs are registered: wr_en, wr_addr, wr_char, busy, cursor.
- busy = 1 from cycle n+1 through the cycle of the last write, inclusive. It falls the cycle after that, and a new request is accepted in that cycle.
- Size 4: 1 write cycle.
- Size 32: 8 write cycles, or 1–8 with suppression.
- Clear: COLS*ROWS write cycles.
- cursor updates in the same cycle as the corresponding wr_en, so it reads wr_addr+1 (wrapped).

## Configuration
- Macro: VGA_TOKEN_WRITER_ZERO_SUPPRESS_EN.
- Defined: for size-32 tokens, leading zero nibbles are skipped. At least one character is always written, so value 0 writes a single '0'. Latency equals the number of significant nibbles.
- Undefined: always 8 characters, including leading zeros.
- Size-4 tokens are unaffected in both cases.

## Test plan
- After reset, tok_strobe with size 4, data 0x7 -> one write in the next cycle: addr 0, char 0x37. cursor = 1, busy high for exactly 1 cycle.
- Strobe size 32, data 0x0000_01F3:
  - Macro off -> 8 writes, "000001F3", at consecutive addresses.
  - Macro on -> 3 writes, "1F3". Value 0 with macro on -> a single '0'.
- Strobe size 4, data 0xC, during a 32-bit emit -> token dropped, ovf = 1, emit completes unaltered.
- Set cursor to COLS*ROWS-2 via repeated strobes, then strobe size 32 with macro off -> writes at 1198, 1199, 0, 1, …, 5. cursor ends at 6.
- clr_req and tok_strobe in the same cycle -> 1200 writes of 0x20 at addresses 0–1199. The token is never written, cursor = 0, ovf stays 0.
- Reset asserted at the 3rd write of an 8-character emit -> wr_en low from the next cycle. busy, ovf and cursor = 0. A subsequent strobe writes at address 0.
